// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared encodings and default addresses for the fetch PC unit
package pc_unit_pkg;

  typedef enum logic [1:0] {
    REDIR_BR   = 2'd0,
    REDIR_JIMM = 2'd1,
    REDIR_JREG = 2'd2,
    REDIR_RSVD = 2'd3
  } redir_kind_e;

  typedef enum logic {
    PCU_RUN  = 1'b0,
    PCU_HOLD = 1'b1
  } pcu_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational redirect target and link address generation
module pc_target_calc
  import pc_unit_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic [1:0]        kind,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr26,
  input  logic [ADDR_W-1:0] jreg,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] link_addr
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_off;

  assign pc4    = id_pc + ADDR_W'(4);
  assign br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  // Reserved kind is never taken by the top, so its target value is don't-care.
  always_comb begin
    case (redir_kind_e'(kind))
      REDIR_BR:   target = pc4 + br_off;
      REDIR_JIMM: target = {pc4[ADDR_W-1:28], jaddr26, 2'b00};
      default:    target = jreg;
    endcase
  end

  assign link_addr = id_pc + (DELAY_SLOT ? ADDR_W'(8) : ADDR_W'(4));

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage PC register, stall-hold redirect FSM and next-PC priority mux
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
  parameter bit                DELAY_SLOT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [1:0]        redir_kind,
  input  logic              branch_cond,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr26,
  input  logic [ADDR_W-1:0] jreg,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              flush_if,
  output logic              fetch_adel,
  output logic              redir_pending
);

  pcu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] hold_tgt, hold_tgt_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] target;
  logic              taken;
  logic              trap;
  logic              redir_upd;

  pc_target_calc #(
    .ADDR_W    (ADDR_W),
    .DELAY_SLOT(DELAY_SLOT)
  ) u_target_calc (
    .kind     (redir_kind),
    .id_pc    (id_pc),
    .imm16    (imm16),
    .jaddr26  (jaddr26),
    .jreg     (jreg),
    .target   (target),
    .link_addr(link_addr)
  );

  assign trap  = exc_req | eret_req;
  assign taken = redir_valid &&
                 ((redir_kind == REDIR_JIMM) || (redir_kind == REDIR_JREG) ||
                  ((redir_kind == REDIR_BR) && branch_cond));

  always_ff @(posedge clk) begin
    if (reset) state <= PCU_RUN;
    else       state <= state_nxt;
  end

  // Traps always return to RUN; a stalled redirect parks in HOLD until stall drops.
  always_comb begin
    state_nxt = state;
    if (state == PCU_HOLD) begin
      if (trap || !stall) state_nxt = PCU_RUN;
    end else begin
      if (!trap && taken && stall) state_nxt = PCU_HOLD;
    end
  end

  always_comb begin
    redir_pending = (state == PCU_HOLD);
    fetch_adel    = |if_pc[1:0];
    flush_if      = !reset && (trap || (!DELAY_SLOT && redir_upd));
  end

  always_comb begin
    pc_nxt       = if_pc;
    hold_tgt_nxt = hold_tgt;
    redir_upd    = 1'b0;
    if (exc_req) begin
      pc_nxt = EXC_VECTOR;
    end else if (eret_req) begin
      pc_nxt = epc;
    end else if (state == PCU_HOLD) begin
      if (!stall) begin
        pc_nxt    = hold_tgt;
        redir_upd = 1'b1;
      end
    end else if (taken) begin
      if (stall) begin
        hold_tgt_nxt = target;
      end else begin
        pc_nxt    = target;
        redir_upd = 1'b1;
      end
    end else if (!stall) begin
      pc_nxt = if_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc    <= RESET_PC;
      hold_tgt <= '0;
    end else begin
      if_pc    <= pc_nxt;
      hold_tgt <= hold_tgt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector table plus randomized model comparison for pc_unit
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, branch_cond, exc_req, eret_req;
  logic [1:0]  redir_kind;
  logic [31:0] id_pc, jreg, epc;
  logic [15:0] imm16;
  logic [25:0] jaddr26;

  logic [31:0] pc1, link1, pc0, link0;
  logic        fl1, adel1, pend1, fl0, adel0, pend0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit #(.ADDR_W(32), .RESET_PC(32'h3000), .EXC_VECTOR(32'h4180), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid), .redir_kind(redir_kind),
    .branch_cond(branch_cond), .id_pc(id_pc), .imm16(imm16), .jaddr26(jaddr26), .jreg(jreg),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .if_pc(pc1), .link_addr(link1),
    .flush_if(fl1), .fetch_adel(adel1), .redir_pending(pend1));

  pc_unit #(.ADDR_W(32), .RESET_PC(32'h3000), .EXC_VECTOR(32'h4180), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid), .redir_kind(redir_kind),
    .branch_cond(branch_cond), .id_pc(id_pc), .imm16(imm16), .jaddr26(jaddr26), .jreg(jreg),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .if_pc(pc0), .link_addr(link0),
    .flush_if(fl0), .fetch_adel(adel0), .redir_pending(pend0));

  typedef struct {
    logic        rst, stl, rv;
    logic [1:0]  kind;
    logic        cond;
    logic [31:0] idpc;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [31:0] jr;
    logic        exc, eret;
    logic [31:0] ep;
    logic [31:0] e_pc;
    logic        e_pend, e_fl1, e_fl0, e_adel;
  } vec_t;

  function automatic vec_t mk(logic rst, logic stl, logic rv, logic [1:0] kind, logic cond,
                              logic [31:0] idpc, logic [15:0] imm, logic [25:0] ja, logic [31:0] jr,
                              logic exc, logic eret, logic [31:0] ep, logic [31:0] e_pc,
                              logic e_pend, logic e_fl1, logic e_fl0, logic e_adel);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.kind = kind; v.cond = cond; v.idpc = idpc;
    v.imm = imm; v.ja = ja; v.jr = jr; v.exc = exc; v.eret = eret; v.ep = ep;
    v.e_pc = e_pc; v.e_pend = e_pend; v.e_fl1 = e_fl1; v.e_fl0 = e_fl0; v.e_adel = e_adel;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst; stall = v.stl; redir_valid = v.rv; redir_kind = v.kind; branch_cond = v.cond;
    id_pc = v.idpc; imm16 = v.imm; jaddr26 = v.ja; jreg = v.jr; exc_req = v.exc;
    eret_req = v.eret; epc = v.ep;
  endtask

  // Reference model state: architectural PC plus an optional parked redirect target.
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_tgt;

  function automatic logic [31:0] ref_target(vec_t v);
    logic [31:0] pc4;
    pc4 = v.idpc + 32'd4;
    case (v.kind)
      2'd0:    return pc4 + 32'($signed(v.imm) * 4);
      2'd1:    return (pc4 & 32'hF000_0000) | (32'(v.ja) * 4);
      default: return v.jr;
    endcase
  endfunction

  function automatic bit ref_taken(vec_t v);
    return v.rv && (v.kind == 2'd1 || v.kind == 2'd2 || (v.kind == 2'd0 && v.cond));
  endfunction

  vec_t vecs[18];
  vec_t r;

  initial begin
    r = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    drive(r);

    vecs[0]  = mk(1,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3000,     0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3004,     0,0,0,0);
    vecs[2]  = mk(0,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3008,     0,0,0,0);
    vecs[3]  = mk(0,0,1,0,1, 32'h3004,  16'hFFFF, 26'h0,       32'h0,    0,0, 32'h0,    32'h3004,     0,0,1,0);
    vecs[4]  = mk(0,1,1,2,0, 32'h3000,  16'h0,    26'h0,       32'h3100, 0,0, 32'h0,    32'h3004,     1,0,0,0);
    vecs[5]  = mk(0,1,1,2,0, 32'h3000,  16'h0,    26'h0,       32'h3100, 0,0, 32'h0,    32'h3004,     1,0,0,0);
    vecs[6]  = mk(0,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3100,     0,0,1,0);
    vecs[7]  = mk(0,1,1,2,0, 32'h3100,  16'h0,    26'h0,       32'h3200, 0,0, 32'h0,    32'h3100,     1,0,0,0);
    vecs[8]  = mk(0,1,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    1,0, 32'h0,    32'h4180,     0,1,1,0);
    vecs[9]  = mk(0,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,1, 32'h3002, 32'h3002,     0,1,1,1);
    vecs[10] = mk(1,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3000,     0,0,0,0);
    vecs[11] = mk(0,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    1,1, 32'h5000, 32'h4180,     0,1,1,0);
    vecs[12] = mk(0,0,1,0,0, 32'h4180,  16'h0010, 26'h0,       32'h0,    0,0, 32'h0,    32'h4184,     0,0,0,0);
    vecs[13] = mk(0,0,1,3,1, 32'h4184,  16'h0,    26'h0,       32'h7000, 0,0, 32'h0,    32'h4188,     0,0,0,0);
    vecs[14] = mk(0,0,1,1,0, 32'h12345678, 16'h0, 26'h0ABCDEF, 32'h0,    0,0, 32'h0,    32'h12AF37BC, 0,0,1,0);
    vecs[15] = mk(0,1,1,2,0, 32'h0,     16'h0,    26'h0,       32'h3100, 0,0, 32'h0,    32'h12AF37BC, 1,0,0,0);
    vecs[16] = mk(1,1,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3000,     0,0,0,0);
    vecs[17] = mk(0,0,0,0,0, 32'h0,     16'h0,    26'h0,       32'h0,    0,0, 32'h0,    32'h3004,     0,0,0,0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d flush_ds1", i), 32'(fl1), 32'(vecs[i].e_fl1));
      chk($sformatf("v%0d flush_ds0", i), 32'(fl0), 32'(vecs[i].e_fl0));
      chk($sformatf("v%0d link_ds1", i), link1, vecs[i].idpc + 32'd8);
      chk($sformatf("v%0d link_ds0", i), link0, vecs[i].idpc + 32'd4);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d if_pc_ds1", i), pc1, vecs[i].e_pc);
      chk($sformatf("v%0d if_pc_ds0", i), pc0, vecs[i].e_pc);
      chk($sformatf("v%0d pending", i), 32'(pend1), 32'(vecs[i].e_pend));
      chk($sformatf("v%0d adel", i), 32'(adel1), 32'(vecs[i].e_adel));
    end

    // Randomized phase: start from reset so the model and both DUTs agree.
    m_pc = 32'h3000; m_held = 0; m_tgt = 32'h0;
    @(negedge clk);
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    for (int n = 0; n < 600; n++) begin
      bit tk, exp_upd;
      @(negedge clk);
      r = mk(($urandom_range(63) == 0), ($urandom_range(2) == 0), $urandom_range(1), 2'($urandom_range(3)),
             $urandom_range(1), $urandom, 16'($urandom), 26'($urandom), $urandom,
             ($urandom_range(15) == 0), ($urandom_range(15) == 0), $urandom,
             0, 0, 0, 0, 0);
      drive(r);
      tk      = ref_taken(r);
      exp_upd = !r.stl && (m_held || tk);
      #1;
      chk("rnd flush_ds1", 32'(fl1), 32'(!r.rst && (r.exc || r.eret)));
      chk("rnd flush_ds0", 32'(fl0), 32'(!r.rst && (r.exc || r.eret || exp_upd)));
      chk("rnd link_ds1", link1, r.idpc + 32'd8);
      if (r.rst) begin
        m_pc = 32'h3000; m_held = 0;
      end else if (r.exc) begin
        m_pc = 32'h4180; m_held = 0;
      end else if (r.eret) begin
        m_pc = r.ep; m_held = 0;
      end else if (m_held) begin
        if (!r.stl) begin m_pc = m_tgt; m_held = 0; end
      end else if (tk) begin
        if (r.stl) begin m_held = 1; m_tgt = ref_target(r); end
        else m_pc = ref_target(r);
      end else if (!r.stl) begin
        m_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      chk("rnd if_pc_ds1", pc1, m_pc);
      chk("rnd if_pc_ds0", pc0, m_pc);
      chk("rnd pending", 32'(pend0), 32'(m_held));
      chk("rnd adel", 32'(adel0), 32'(m_pc[1:0] != 2'b00));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
